// File: rtl/stepper_phase_decoder.sv
// stepper_phase_decoder
//
// Receive-side decoder for a four-coil stepper drive. It watches the coil
// lines {jb1,jb2,jb3,jb4}, recovers half/full-step motion from the phase
// sequence, and reports a signed position, direction, step strobe and sticky
// error flags.
//
// Ports:
//   clk          system clock (only clock of the block)
//   reset        asynchronous, active-high reset
//   jb1..jb4     coil lines, asynchronous to clk; pattern = {jb1,jb2,jb3,jb4}
//   clear        synchronous: zero the position
//   err_clr      synchronous: clear err_skip and err_illegal
//   position     signed step count (POS_WIDTH bits)
//   dir          direction of the last accepted step, 1 = forward
//   step_pulse   one-cycle strobe per accepted step
//   phase_idx    index of the last accepted valid phase
//   locked       phase reference established
//   err_skip     sticky: phase jump of 3, 4 or 5 seen
//   err_illegal  sticky: non-table, non-idle pattern accepted
//
// Build option:
//   STEP_DECODER_SAT_EN  when defined, position saturates at the signed limits
//                        instead of wrapping modulo 2^POS_WIDTH.

module stepper_phase_decoder #(
    parameter int POS_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        jb1,
    input  logic                        jb2,
    input  logic                        jb3,
    input  logic                        jb4,
    input  logic                        clear,
    input  logic                        err_clr,
    output logic signed [POS_WIDTH-1:0] position,
    output logic                        dir,
    output logic                        step_pulse,
    output logic [2:0]                  phase_idx,
    output logic                        locked,
    output logic                        err_skip,
    output logic                        err_illegal
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer chain
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [SYNC_STAGES-1:0][3:0] sync_d;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = {jb1, jb2, jb3, jb4};
            end else begin : g_rest
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    logic [3:0] sync_out;
    assign sync_out = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]                  prev_q, prev_d;     // pattern being timed
    logic [CNT_W-1:0]            cnt_q, cnt_d;       // cycles prev has held
    logic [3:0]                  acc_q, acc_d;       // last accepted pattern
    state_t                      state_q, state_d;
    logic                        locked_q, locked_d;
    logic [2:0]                  phase_idx_q, phase_idx_d;
    logic signed [POS_WIDTH-1:0] position_q, position_d;
    logic                        dir_q, dir_d;
    logic                        step_pulse_q, step_pulse_d;
    logic                        err_skip_q, err_skip_d;
    logic                        err_illegal_q, err_illegal_d;

    // ------------------------------------------------------------------
    // Combinational next state
    // ------------------------------------------------------------------
    logic                        accept;
    logic                        tbl_valid;
    logic [2:0]                  tbl_idx;
    logic [2:0]                  phase_delta;
    logic                        do_step;
    logic signed [POS_WIDTH-1:0] step_amt;
    logic signed [POS_WIDTH-1:0] pos_next;
`ifdef STEP_DECODER_SAT_EN
    logic [POS_WIDTH:0]          pos_sum;
`endif

    always_comb begin
        // Stability counter: restart on any change, saturate at DEBOUNCE.
        prev_d = prev_q;
        cnt_d  = cnt_q;
        if (sync_out != prev_q) begin
            prev_d = sync_out;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A stable pattern is accepted once; holding it produces nothing more.
        accept = (cnt_q >= CNT_MAX) && (prev_q != acc_q);
        acc_d  = accept ? prev_q : acc_q;

        tbl_valid = 1'b1;
        tbl_idx   = 3'd0;
        case (prev_q)
            4'b1000: tbl_idx = 3'd0;
            4'b1100: tbl_idx = 3'd1;
            4'b0100: tbl_idx = 3'd2;
            4'b0110: tbl_idx = 3'd3;
            4'b0010: tbl_idx = 3'd4;
            4'b0011: tbl_idx = 3'd5;
            4'b0001: tbl_idx = 3'd6;
            4'b1001: tbl_idx = 3'd7;
            default: tbl_valid = 1'b0;
        endcase

        // 3-bit subtraction gives the forward distance mod 8 directly.
        phase_delta = tbl_idx - phase_idx_q;

        state_d       = state_q;
        locked_d      = locked_q;
        phase_idx_d   = phase_idx_q;
        position_d    = position_q;
        dir_d         = dir_q;
        step_pulse_d  = 1'b0;
        err_skip_d    = err_skip_q & ~err_clr;
        err_illegal_d = err_illegal_q & ~err_clr;
        do_step       = 1'b0;
        step_amt      = '0;

        // Idle (0000) is accepted only to re-arm acceptance; it has no effect.
        if (accept && (prev_q != 4'b0000)) begin
            if (!tbl_valid) begin
                err_illegal_d = 1'b1;
                state_d       = ST_UNLOCKED;
                locked_d      = 1'b0;
            end else if (state_q == ST_UNLOCKED) begin
                phase_idx_d = tbl_idx;
                state_d     = ST_LOCKED;
                locked_d    = 1'b1;
            end else begin
                phase_idx_d = tbl_idx;
                case (phase_delta)
                    3'd1: begin do_step = 1'b1; step_amt = POS_WIDTH'(1);  dir_d = 1'b1; end
                    3'd2: begin do_step = 1'b1; step_amt = POS_WIDTH'(2);  dir_d = 1'b1; end
                    3'd7: begin do_step = 1'b1; step_amt = POS_WIDTH'(-1); dir_d = 1'b0; end
                    3'd6: begin do_step = 1'b1; step_amt = POS_WIDTH'(-2); dir_d = 1'b0; end
                    3'd3, 3'd4, 3'd5: err_skip_d = 1'b1;
                    default: ;
                endcase
            end
        end

`ifdef STEP_DECODER_SAT_EN
        // One guard bit: overflow shows as the two top bits disagreeing.
        pos_sum = {position_q[POS_WIDTH-1], position_q} + {step_amt[POS_WIDTH-1], step_amt};
        if (pos_sum[POS_WIDTH] != pos_sum[POS_WIDTH-1]) begin
            pos_next = pos_sum[POS_WIDTH] ? {1'b1, {(POS_WIDTH-1){1'b0}}}
                                          : {1'b0, {(POS_WIDTH-1){1'b1}}};
        end else begin
            pos_next = pos_sum[POS_WIDTH-1:0];
        end
`else
        pos_next = position_q + step_amt;
`endif

        if (do_step) begin
            position_d   = pos_next;
            step_pulse_d = 1'b1;
        end
        // clear wins over the position update only; dir and pulse still follow the step.
        if (clear) begin
            position_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q        <= '0;
            prev_q        <= '0;
            cnt_q         <= '0;
            acc_q         <= '0;
            state_q       <= ST_UNLOCKED;
            locked_q      <= 1'b0;
            phase_idx_q   <= '0;
            position_q    <= '0;
            dir_q         <= 1'b0;
            step_pulse_q  <= 1'b0;
            err_skip_q    <= 1'b0;
            err_illegal_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            state_q       <= state_d;
            locked_q      <= locked_d;
            phase_idx_q   <= phase_idx_d;
            position_q    <= position_d;
            dir_q         <= dir_d;
            step_pulse_q  <= step_pulse_d;
            err_skip_q    <= err_skip_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    assign position    = position_q;
    assign dir         = dir_q;
    assign step_pulse  = step_pulse_q;
    assign phase_idx   = phase_idx_q;
    assign locked      = locked_q;
    assign err_skip    = err_skip_q;
    assign err_illegal = err_illegal_q;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Testbench for stepper_phase_decoder. A reduced position width keeps the
// overflow scenario short. A behavioural model (input history window plus
// integer position) is compared against the DUT every cycle; directed
// scenarios add literal expectations.

module tb_stepper_phase_decoder;

    localparam int PW   = 8;
    localparam int S    = 2;
    localparam int D    = 4;
    localparam int PMAX = 2**(PW-1) - 1;
    localparam int PMIN = -(2**(PW-1));

    logic clk = 1'b0;
    logic reset;
    logic jb1, jb2, jb3, jb4;
    logic clear, err_clr;
    logic signed [PW-1:0] position;
    logic dir, step_pulse, locked, err_skip, err_illegal;
    logic [2:0] phase_idx;

    stepper_phase_decoder #(
        .POS_WIDTH  (PW),
        .SYNC_STAGES(S),
        .DEBOUNCE   (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .jb1        (jb1),
        .jb2        (jb2),
        .jb3        (jb3),
        .jb4        (jb4),
        .clear      (clear),
        .err_clr    (err_clr),
        .position   (position),
        .dir        (dir),
        .step_pulse (step_pulse),
        .phase_idx  (phase_idx),
        .locked     (locked),
        .err_skip   (err_skip),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pulse_total = 0;

    logic [3:0] phase_tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                  4'b0010, 4'b0011, 4'b0001, 4'b1001};

    // ---------------- behavioural model ----------------
    logic [3:0] hist [$];
    logic [3:0] m_acc;
    int  m_pos, m_idx;
    bit  m_dir, m_pulse, m_locked, m_skip, m_ill;

    function automatic int find_phase(logic [3:0] p);
        for (int i = 0; i < 8; i++) if (phase_tbl[i] == p) return i;
        return -1;
    endfunction

    function automatic int limit(int v);
`ifdef STEP_DECODER_SAT_EN
        if (v > PMAX) return PMAX;
        if (v < PMIN) return PMIN;
        return v;
`else
        int span;
        span = 2**PW;
        return ((v - PMIN) % span + span) % span + PMIN;
`endif
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist.delete();
            for (int i = 0; i < S + D + 1; i++) hist.push_back(4'b0000);
            m_acc = 4'b0000; m_pos = 0; m_idx = 0;
            m_dir = 0; m_pulse = 0; m_locked = 0; m_skip = 0; m_ill = 0;
        end else begin
            logic [3:0] p;
            bit same;
            int ni, d;
            hist.push_back({jb1, jb2, jb3, jb4});
            void'(hist.pop_front());
            m_pulse = 0;
            if (err_clr) begin m_skip = 0; m_ill = 0; end
            // hist[0..D-1] are the samples that have just finished the
            // synchronizer and must all agree for acceptance at this edge.
            same = 1;
            for (int i = 1; i < D; i++) if (hist[i] != hist[0]) same = 0;
            if (same && hist[0] != m_acc) begin
                p = hist[0];
                m_acc = p;
                if (p != 4'b0000) begin
                    ni = find_phase(p);
                    if (ni < 0) begin
                        m_ill = 1; m_locked = 0;
                    end else if (!m_locked) begin
                        m_idx = ni; m_locked = 1;
                    end else begin
                        d = (ni - m_idx + 8) % 8;
                        m_idx = ni;
                        if (d == 1 || d == 2) begin
                            m_pos = limit(m_pos + d); m_dir = 1; m_pulse = 1;
                        end else if (d == 6 || d == 7) begin
                            m_pos = limit(m_pos - (8 - d)); m_dir = 0; m_pulse = 1;
                        end else if (d >= 3 && d <= 5) begin
                            m_skip = 1;
                        end
                    end
                end
            end
            if (clear) m_pos = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            tests++;
            if (position !== PW'(m_pos) || dir !== m_dir || step_pulse !== m_pulse ||
                phase_idx !== 3'(m_idx) || locked !== m_locked ||
                err_skip !== m_skip || err_illegal !== m_ill) begin
                fails++;
                $display("FAIL cycle t=%0t: got pos=%0d dir=%0b pulse=%0b idx=%0d lock=%0b skip=%0b ill=%0b, need pos=%0d dir=%0b pulse=%0b idx=%0d lock=%0b skip=%0b ill=%0b",
                         $time, position, dir, step_pulse, phase_idx, locked, err_skip, err_illegal,
                         m_pos, m_dir, m_pulse, m_idx, m_locked, m_skip, m_ill);
            end
            if (step_pulse === 1'b1) pulse_total++;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(string name, int actual, int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, need %0d", name, actual, expected);
        end else begin
            $display("[TB] %s ok (%0d)", name, actual);
        end
    endtask

    task automatic hold(logic [3:0] p, int n);
        {jb1, jb2, jb3, jb4} = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1'b1; @(negedge clk); clear = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int base, n, ref_idx;
        reset = 1'b1;
        {jb1, jb2, jb3, jb4} = 4'b0000;
        clear = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_position", int'(position), 0);
        check("reset_flags", {dir, step_pulse, locked, err_skip, err_illegal}, 0);
        check("reset_phase_idx", phase_idx, 0);
        reset = 1'b0;

        // Forward half-steps through 17 patterns.
        base = pulse_total;
        for (int i = 0; i < 17; i++) hold(phase_tbl[i % 8], 10);
        check("fwd_locked", locked, 1);
        check("fwd_position", int'(position), 16);
        check("fwd_model_position", m_pos, 16);
        check("fwd_dir", dir, 1);
        check("fwd_pulses", pulse_total - base, 16);
        check("fwd_errors", {err_skip, err_illegal}, 0);

        // Full steps (+2 each) then one reverse full step.
        hold(4'b1100, 10);
        pulse_clear();
        check("full_cleared", int'(position), 0);
        hold(4'b0110, 10);
        hold(4'b0011, 10);
        hold(4'b1001, 10);
        hold(4'b1100, 10);
        check("full_position", int'(position), 8);
        hold(4'b1001, 10);
        check("rev_position", int'(position), 6);
        check("rev_dir", dir, 0);

        // Skip of 4 phases.
        hold(4'b1000, 10);
        check("pre_skip_position", int'(position), 7);
        base = pulse_total;
        hold(4'b0010, 10);
        check("skip_flag", err_skip, 1);
        check("skip_position", int'(position), 7);
        check("skip_pulses", pulse_total - base, 0);
        check("skip_phase_idx", phase_idx, 4);
        pulse_err_clr();
        check("skip_cleared", err_skip, 0);

        // Illegal pattern, then re-lock.
        hold(4'b1010, 10);
        check("illegal_flag", err_illegal, 1);
        check("illegal_unlocked", locked, 0);
        check("illegal_position", int'(position), 7);
        base = pulse_total;
        hold(4'b0100, 10);
        check("relock_locked", locked, 1);
        check("relock_position", int'(position), 7);
        check("relock_pulses", pulse_total - base, 0);
        check("relock_phase_idx", phase_idx, 2);
        pulse_err_clr();
        check("illegal_cleared", err_illegal, 0);

        // Glitch rejection and idle.
        hold(4'b1000, 10);
        check("back2_position", int'(position), 5);
        base = pulse_total;
        hold(4'b1100, 3);
        hold(4'b1000, 10);
        check("glitch_pulses", pulse_total - base, 0);
        check("glitch_phase_idx", phase_idx, 0);
        hold(4'b0000, 20);
        check("idle_position", int'(position), 5);
        check("idle_locked", locked, 1);
        check("idle_pulses", pulse_total - base, 0);

        // Latency from first sampling edge to step_pulse.
        {jb1, jb2, jb3, jb4} = 4'b1100;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (step_pulse) break;
        end
        check("latency_edges", n - 1, 6);
        repeat (4) @(negedge clk);
        check("latency_position", int'(position), 6);

        // Overflow: climb to PMAX-1 in full steps, then two half steps.
        pulse_clear();
        ref_idx = 1;
        for (int k = 0; k < (PMAX - 1) / 2; k++) begin
            ref_idx = (ref_idx + 2) % 8;
            hold(phase_tbl[ref_idx], 6);
        end
        ref_idx = (ref_idx + 1) % 8;
        hold(phase_tbl[ref_idx], 10);
        check("ovf_at_max", int'(position), PMAX);
        base = pulse_total;
        ref_idx = (ref_idx + 1) % 8;
        hold(phase_tbl[ref_idx], 10);
`ifdef STEP_DECODER_SAT_EN
        check("ovf_step", int'(position), PMAX);
`else
        check("ovf_step", int'(position), PMIN);
`endif
        check("ovf_pulses", pulse_total - base, 1);
        check("ovf_dir", dir, 1);

        // clear coincident with an accepted step.
        ref_idx = (ref_idx + 1) % 8;
        {jb1, jb2, jb3, jb4} = phase_tbl[ref_idx];
        repeat (6) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_step_pulse", step_pulse, 1);
        check("clear_step_position", int'(position), 0);
        check("clear_step_dir", dir, 1);
        repeat (4) @(negedge clk);

        // err_clr coincident with a new skip error: flag ends set.
        ref_idx = (ref_idx + 4) % 8;
        hold(phase_tbl[ref_idx], 10);
        check("skip2_flag", err_skip, 1);
        ref_idx = (ref_idx + 4) % 8;
        {jb1, jb2, jb3, jb4} = phase_tbl[ref_idx];
        repeat (6) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("errclr_vs_new_error", err_skip, 1);
        repeat (4) @(negedge clk);
        pulse_err_clr();

        // Step forward, then asynchronous reset mid-operation.
        ref_idx = (ref_idx + 1) % 8;
        hold(phase_tbl[ref_idx], 10);
        check("pre_reset_position", int'(position), 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_position", int'(position), 0);
        check("async_reset_flags", {dir, locked, err_skip, err_illegal}, 0);
        check("async_reset_phase_idx", phase_idx, 0);
        @(negedge clk);
        reset = 1'b0;
        base = pulse_total;
        hold(phase_tbl[ref_idx], 10);
        check("post_reset_locked", locked, 1);
        check("post_reset_position", int'(position), 0);
        check("post_reset_pulses", pulse_total - base, 0);
        check("post_reset_phase_idx", phase_idx, ref_idx);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stepper_phase_decoder.md
# stepper_phase_decoder

Monitors the four stepper coil drive lines (jb1..jb4) and recovers motion from the phase sequence. It decodes half-step and full-step patterns into a signed position, a direction flag and a one-cycle step strobe, and flags skipped or illegal phases. It sits alongside the stepper motor controller as its receive-side counterpart. It gives the claw-machine processor or a bench closed-loop visibility of commanded motion.

## Interface
- POS_WIDTH, 16, width of the signed position counter
- SYNC_STAGES, 2, flip-flop synchronizer depth on jb1..jb4 (minimum 2)
- DEBOUNCE, 4, consecutive cycles a synchronized pattern must hold before it is accepted (minimum 1)

- clk  in  1  system clock; the block's only clock
- reset  in  1  asynchronous, active-high reset
- jb1, jb2, jb3, jb4  in  1 each  coil lines; pattern is {jb1,jb2,jb3,jb4}; asynchronous to clk
- clear  in  1  synchronous: zero position
- err_clr  in  1  synchronous: clear both sticky error flags
- position  out  POS_WIDTH  signed step count; reset 0
- dir  out  1  direction of last accepted step, 1 = forward; reset 0
- step_pulse  out  1  one-cycle strobe per accepted step event; reset 0
- phase_idx  out  3  index of last accepted valid phase; reset 0
- locked  out  1  phase reference established; reset 0
- err_skip  out  1  sticky: a phase jump of 3, 4 or 5 was seen; reset 0
- err_illegal  out  1  sticky: a non-table, non-idle pattern was accepted; reset 0

## Operation
- Phase table, index -> pattern: 0=1000, 1=1100, 2=0100, 3=0110, 4=0010, 5=0011, 6=0001, 7=1001.
- 0000 is idle (coils off). It is accepted but ignored: no state, position, error or pulse change.
- Every other pattern is illegal.
- Front end: SYNC_STAGES-deep synchronizer, then a stability counter.
  - Any change in the synchronized pattern restarts the counter.
  - A pattern is accepted once, when it has held for DEBOUNCE consecutive cycles and differs from the last accepted pattern.
- State machine, two states, reset -> UNLOCKED.
  - UNLOCKED, valid pattern accepted: load phase_idx, go LOCKED, locked=1. No step, no pulse.
  - UNLOCKED, illegal pattern accepted: set err_illegal, stay UNLOCKED.
  - LOCKED, valid pattern accepted: d = (new - phase_idx) mod 8, then act on d as below. phase_idx <= new in every case.
  - LOCKED, illegal pattern accepted: set err_illegal, go UNLOCKED, locked=0. position and phase_idx hold.
- Action on d in LOCKED:
  - d=1: position +1, dir=1, pulse.
  - d=2: position +2, dir=1, pulse.
  - d=7: position -1, dir=0, pulse.
  - d=6: position -2, dir=0, pulse.
  - d=3, 4 or 5: set err_skip, position and dir hold, no pulse.
- Arithmetic: two's-complement POS_WIDTH bits. Overflow behaviour is set by Configuration.
- Priority rules:
  - clear with a step in the same cycle: position=0, but dir and step_pulse still reflect the step.
  - err_clr with a new error in the same cycle: the flag ends set.
  - clear and err_clr do not affect locked or phase_idx.

## Timing
- An accepted event updates position, dir, phase_idx, locked and the error flags on the same clock edge that asserts step_pulse.
- Latency: a new pattern first sampled at edge N produces step_pulse high after edge N+SYNC_STAGES+DEBOUNCE, for one cycle. This is 6 edges at defaults.
- Pulses shorter than DEBOUNCE synchronized cycles are rejected with no output effect.
- Minimum accepted step interval: DEBOUNCE cycles. Back-to-back accepted steps give separate pulses.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously). The synchronizer and stability counter clear. After release the first accepted pattern only re-locks.

## Configuration
- STEP_DECODER_SAT_EN defined: position saturates at +(2^(POS_WIDTH-1)-1) and -2^(POS_WIDTH-1).
  - A step that would overflow clamps to the limit.
  - step_pulse and dir still update.
- Undefined: position wraps modulo 2^POS_WIDTH.

## Test plan
- Reset, then drive 1000, 1100, 0100, ... forward through 17 half-step patterns, each held 10 cycles -> locked=1 after the first; position=16, dir=1, 16 step_pulses, no errors.
- Locked at 1000, full-step 1100 -> 0110 -> 0011 -> 1001 -> 1100 -> position +8 in steps of 2, then reverse 1001 -> position 6, dir=0.
- Locked at 1000, drive 0010 (d=4) -> err_skip=1, position unchanged, no pulse. Assert err_clr -> err_skip=0.
- Locked, drive 1010 for 10 cycles -> err_illegal=1, locked=0, position held. Next 0100 re-locks with no position change.
- Locked at 1000, glitch 1100 for 3 cycles then back to 1000 -> no pulse, no change. Then 0000 for 20 cycles -> no change.
- Position at 32767, one forward step -> 32767 with STEP_DECODER_SAT_EN, -32768 without it. Assert clear together with a step -> position 0, step_pulse=1.
